mul4_seq: RTL and testbench

//   Sequential unsigned shift-and-add multiplier. Each step does one W-bit
//   add with carry-out: the 4-bit ripple adder function (a+b, ci=0 -> s,co)
//   at the default W=4.
//   - Accepts an operand pair on a start pulse.
//   - Iterates one add-and-shift step per clock.
//   - Presents the 2W-bit product with a one-cycle done strobe.
//   - Sits between the operand source and the result consumer in the arithmetic datapath.

---
 rtl/mul4_seq.sv | 115 +++++++++++
 tb/tb_mul4_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul4_seq.sv
// Sequential unsigned shift-and-add multiplier.
// An accepted start captures the operands. One add-and-shift step is done per
// clock for W steps, then the 2W-bit product is presented with a one-cycle
// done strobe.
//
// state | meaning
// IDLE  | ready for a new operand pair (ready=1)
// CALC  | iterating add-and-shift steps (busy=1)
// DONE  | product just updated on p (done=1), one cycle only
module mul4_seq #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   p
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       m_q, m_d;
    logic [W-1:0]       h_q, h_d;
    logic [W-1:0]       l_q, l_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     p_q, p_d;

    // The carry (C) is produced and consumed inside the same step: it lands
    // in H[W-1] by the shift, so it never needs its own storage element.
    logic [W-1:0]       addend;
    logic [W:0]         step_sum;
    logic [2*W:0]       step_shift;

    // Register update with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            h_q     <= '0;
            l_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            h_q     <= h_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Next-state logic plus one add-with-carry-and-shift step.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        h_d     = h_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        // {C,H} = H + (L[0] ? M : 0), then {H,L} = {C,H,L} >> 1.
        addend     = l_q[0] ? m_q : '0;
        step_sum   = {1'b0, h_q} + {1'b0, addend};
        step_shift = {step_sum, l_q} >> 1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    l_d     = b;
                    h_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                h_d   = step_shift[2*W-1:W];
                l_d   = step_shift[W-1:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = step_shift[2*W-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags decode only the registered state.
    always_comb begin
        ready = (state_q == IDLE);
        busy  = (state_q == CALC);
        done  = (state_q == DONE);
        p     = p_q;
    end

endmodule

// File: tb/tb_mul4_seq.sv
// Self-checking bench for mul4_seq at W=4 and W=8 against a plain a*b model.
module tb_mul4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       ready4, busy4, done4;
    logic       ready8, busy8, done8;
    logic [7:0]  p4;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul4_seq #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .ready(ready4), .busy(busy4), .done(done4), .p(p4)
    );

    mul4_seq #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .p(p8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full W=4 operation: wait for ready, accept, scramble inputs while
    // computing, then check latency, result, p stability and return to IDLE.
    task automatic op4(input logic [3:0] x, input logic [3:0] y, input string tag);
        int         cyc;
        logic [7:0] p_prev;
        logic [7:0] expv;
        logic       stable_ok;
        logic       busy_ok;
        expv = 8'(int'(x) * int'(y));
        cyc = 0;
        while (!ready4 && cyc < 20) begin
            tick();
            cyc++;
        end
        total++;
        if (ready4 !== 1'b1) begin
            bad++;
            $display("FAIL %s ready_wait got=%b want=1", tag, ready4);
        end
        p_prev = p4;
        a4 = x;
        b4 = y;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cyc = 0;
        stable_ok = 1'b1;
        busy_ok = 1'b1;
        while (done4 !== 1'b1 && cyc < 20) begin
            if (p4 !== p_prev) stable_ok = 1'b0;
            if (busy4 !== 1'b1 || ready4 !== 1'b0) busy_ok = 1'b0;
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            tick();
            cyc++;
        end
        total++;
        if (cyc != 4) begin
            bad++;
            $display("FAIL %s latency got=%0d want=4", tag, cyc);
        end
        total++;
        if (p4 !== expv) begin
            bad++;
            $display("FAIL %s product got=%0d want=%0d", tag, p4, expv);
        end
        total++;
        if (!stable_ok || !busy_ok) begin
            bad++;
            $display("FAIL %s calc_phase stable=%b busy=%b want 1 1", tag, stable_ok, busy_ok);
        end
        tick();
        total++;
        if (ready4 !== 1'b1 || done4 !== 1'b0 || p4 !== expv) begin
            bad++;
            $display("FAIL %s after_done ready=%b done=%b p=%0d want 1 0 %0d",
                     tag, ready4, done4, p4, expv);
        end
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input string tag);
        int          cyc;
        logic [15:0] expv;
        expv = 16'(int'(x) * int'(y));
        cyc = 0;
        while (!ready8 && cyc < 30) begin
            tick();
            cyc++;
        end
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        cyc = 0;
        while (done8 !== 1'b1 && cyc < 30) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            tick();
            cyc++;
        end
        total++;
        if (cyc != 8) begin
            bad++;
            $display("FAIL %s latency got=%0d want=8", tag, cyc);
        end
        total++;
        if (p8 !== expv) begin
            bad++;
            $display("FAIL %s product got=%0d want=%0d", tag, p8, expv);
        end
        tick();
        total++;
        if (ready8 !== 1'b1 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done ready=%b done=%b want 1 0", tag, ready8, done8);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'd0) begin
            bad++;
            $display("FAIL reset4 ready=%b busy=%b done=%b p=%0d want 1 0 0 0",
                     ready4, busy4, done4, p4);
        end
        total++;
        if (ready8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0) begin
            bad++;
            $display("FAIL reset8 ready=%b busy=%b done=%b p=%0d want 1 0 0 0",
                     ready8, busy8, done8, p8);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        op4(4'd3, 4'd5, "basic_3x5");
    endtask

    task automatic test_carry();
        op4(4'd15, 4'd15, "carry_15x15");
        op4(4'd15, 4'd13, "carry_15x13");
    endtask

    task automatic test_zero();
        op4(4'd0, 4'd9, "zero_0x9");
        op4(4'd9, 4'd0, "zero_9x0");
    endtask

    // start held high: one accept per W+2 cycles, inputs scrambled mid-CALC.
    task automatic test_back_to_back();
        int n_done;
        int last_done;
        logic onehot_ok;
        n_done = 0;
        last_done = -1;
        onehot_ok = 1'b1;
        start4 = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (busy4 === 1'b1) begin
                a4 = 4'($urandom);
                b4 = 4'($urandom);
            end else begin
                a4 = 4'd7;
                b4 = 4'd6;
            end
            tick();
            if ((int'(ready4) + int'(busy4) + int'(done4)) != 1) onehot_ok = 1'b0;
            if (done4 === 1'b1) begin
                total++;
                if (p4 !== 8'd42) begin
                    bad++;
                    $display("FAIL b2b_product got=%0d want=42", p4);
                end
                if (last_done >= 0) begin
                    total++;
                    if (i - last_done != 6) begin
                        bad++;
                        $display("FAIL b2b_spacing got=%0d want=6", i - last_done);
                    end
                end
                last_done = i;
                n_done++;
            end
        end
        start4 = 1'b0;
        total++;
        if (n_done != 4) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=4", n_done);
        end
        total++;
        if (!onehot_ok) begin
            bad++;
            $display("FAIL b2b_onehot got=0 want=1");
        end
    endtask

    task automatic test_abort();
        int cyc;
        cyc = 0;
        while (!ready4 && cyc < 20) begin
            tick();
            cyc++;
        end
        total++;
        if (p4 !== 8'd42) begin
            bad++;
            $display("FAIL abort_pre_p got=%0d want=42", p4);
        end
        a4 = 4'd12;
        b4 = 4'd11;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (ready4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0 || p4 !== 8'd0) begin
            bad++;
            $display("FAIL abort_state ready=%b busy=%b done=%b p=%0d want 1 0 0 0",
                     ready4, busy4, done4, p4);
        end
        op4(4'd2, 4'd3, "abort_then_2x3");
    endtask

    task automatic test_exhaustive4();
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                op4(4'(i), 4'(j), "exh4");
            end
        end
    endtask

    task automatic test_w8();
        op8(8'd255, 8'd255, "w8_255x255");
        op8(8'd0, 8'd200, "w8_0x200");
        op8(8'd200, 8'd0, "w8_200x0");
        op8(8'd1, 8'd255, "w8_1x255");
        for (int k = 0; k < 60; k++) begin
            op8(8'($urandom), 8'($urandom), "w8_rand");
        end
    endtask

    initial begin
        rst = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        a4 = '0;
        b4 = '0;
        a8 = '0;
        b8 = '0;
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_back_to_back();
        test_abort();
        test_exhaustive4();
        test_w8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
